// File: rtl/picomips_pkg.sv
`default_nettype none
// ============================================================================
// Module : picomips_pkg
// Brief  : Shared picoMips opcodes, instruction defaults and load FSM states.
// Rev    : 1.0
// ============================================================================
package picomips_pkg;

  localparam int INSTR_W = 10;
  localparam int OPC_W   = 3;
  localparam logic [INSTR_W-1:0] NOP_WORD = '0;

  // Opcode 0 is left free so that an all-zero word decodes as NOP.
  localparam logic [OPC_W-1:0] OP_HEI  = 3'd1;
  localparam logic [OPC_W-1:0] OP_LS   = 3'd2;
  localparam logic [OPC_W-1:0] OP_MULI = 3'd3;
  localparam logic [OPC_W-1:0] OP_AR   = 3'd4;
  localparam logic [OPC_W-1:0] OP_ADDR = 3'd5;
  localparam logic [OPC_W-1:0] OP_LR   = 3'd6;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2
  } load_state_t;

endpackage
`default_nettype wire

// File: rtl/program_store_ram.sv
`default_nettype none
// ============================================================================
// Module : program_store_ram
// Brief  : Synchronous-write, synchronous-read instruction array.
// Rev    : 1.0
// ============================================================================
module program_store_ram #(
  parameter int ADDR_W = 5,
  parameter int INSTR_W = 10,
  parameter int DEPTH = 32,
  parameter logic [INSTR_W-1:0] INIT_WORD = '0
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  // Configuration-time contents; reset never touches the array.
  logic [INSTR_W-1:0] r_mem [DEPTH] = '{default: INIT_WORD};
  logic [INSTR_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/program_store.sv
`default_nettype none
// ============================================================================
// Module : program_store
// Brief  : Field-loadable picoMips program memory with NOP-filling load FSM.
// Rev    : 1.0
// ============================================================================
module program_store #(
  parameter int ADDR_W = 5,
  parameter int INSTR_W = picomips_pkg::INSTR_W,
  parameter int DEPTH = 2**ADDR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = picomips_pkg::NOP_WORD
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic               Fetch_en,
  output logic [INSTR_W-1:0] Instruction,
  input  logic               Load_start,
  input  logic               Load_valid,
  input  logic [INSTR_W-1:0] Load_data,
  input  logic               Load_last,
  output logic               Load_ready,
  output logic               Loading,
  output logic [ADDR_W:0]    Load_count,
  output logic               Load_error
);

  import picomips_pkg::*;

  localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);

  load_state_t        r_state;
  logic [ADDR_W-1:0]  r_wp;
  logic [ADDR_W:0]    r_count;
  logic               r_error;
  logic               r_fetch_nop;

  logic               w_in_range;
  logic               w_we;
  logic               w_re;
  logic [INSTR_W-1:0] w_wdata;
  logic [INSTR_W-1:0] w_rdata;

  assign w_in_range = {1'b0, Addr} < c_DEPTH;
  assign w_we       = !Reset && (((r_state == LOAD) && Load_valid) || (r_state == FILL));
  assign w_wdata    = (r_state == FILL) ? NOP_WORD : Load_data;
  // Array read is suppressed when the result would be forced to NOP anyway.
  assign w_re       = Fetch_en && w_in_range && (r_state == IDLE);

  program_store_ram #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .DEPTH     (DEPTH),
    .INIT_WORD (NOP_WORD)
  ) u_ram (
    .clk   (Clock),
    .we    (w_we),
    .waddr (r_wp),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (Addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_wp        <= '0;
      r_count     <= '0;
      r_error     <= 1'b0;
      r_fetch_nop <= 1'b1;
    end else begin
      if (Fetch_en) begin
        r_fetch_nop <= !w_in_range || (r_state != IDLE);
      end
      case (r_state)
        IDLE: begin
          if (Load_start) begin
            r_state <= LOAD;
            r_wp    <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        LOAD: begin
          if (Load_valid) begin
            r_wp    <= r_wp + 1'b1;
            r_count <= r_count + 1'b1;
            if (r_wp == c_LAST) begin
              r_state <= IDLE;
              r_error <= !Load_last;
            end else if (Load_last) begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          r_wp <= r_wp + 1'b1;
          if (r_wp == c_LAST) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Instruction = r_fetch_nop ? NOP_WORD : w_rdata;
  assign Load_ready  = (r_state == LOAD);
  assign Loading     = (r_state != IDLE);
  assign Load_count  = r_count;
  assign Load_error  = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_store.sv
`default_nettype none
// ============================================================================
// Module : tb_program_store
// Brief  : Directed self-checking bench for program_store (DEPTH 32 and 20).
// Rev    : 1.0
// ============================================================================
module tb_program_store;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] Addr,  Addr2;
  logic       Fetch_en, Fetch_en2;
  logic [9:0] Instruction, Instruction2;
  logic       Load_start, Load_start2, Load_valid, Load_valid2, Load_last, Load_last2;
  logic [9:0] Load_data, Load_data2;
  logic       Load_ready, Load_ready2, Loading, Loading2, Load_error, Load_error2;
  logic [5:0] Load_count, Load_count2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cyc2   = 0;

  always #5 Clock = ~Clock;

  program_store dut (
    .Clock(Clock), .Reset(Reset), .Addr(Addr), .Fetch_en(Fetch_en),
    .Instruction(Instruction), .Load_start(Load_start), .Load_valid(Load_valid),
    .Load_data(Load_data), .Load_last(Load_last), .Load_ready(Load_ready),
    .Loading(Loading), .Load_count(Load_count), .Load_error(Load_error)
  );

  program_store #(.DEPTH(20)) dut20 (
    .Clock(Clock), .Reset(Reset), .Addr(Addr2), .Fetch_en(Fetch_en2),
    .Instruction(Instruction2), .Load_start(Load_start2), .Load_valid(Load_valid2),
    .Load_data(Load_data2), .Load_last(Load_last2), .Load_ready(Load_ready2),
    .Loading(Loading2), .Load_count(Load_count2), .Load_error(Load_error2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Advances one cycle, counting it if the main DUT was loading during it.
  task automatic step_ld();
    if (Loading) cyc++;
    step();
  endtask

  task automatic step2();
    if (Loading2) cyc2++;
    step();
  endtask

  task automatic put(input logic [9:0] d, input logic last);
    Load_valid = 1'b1;
    Load_data  = d;
    Load_last  = last;
    step_ld();
    Load_valid = 1'b0;
    Load_last  = 1'b0;
  endtask

  task automatic fetch(input int a, input logic [9:0] exp);
    Addr     = 5'(a);
    Fetch_en = 1'b1;
    step();
    Fetch_en = 1'b0;
    chk($sformatf("fetch[%0d]", a), 32'(Instruction), 32'(exp));
  endtask

  task automatic fetch2(input int a, input logic [9:0] exp);
    Addr2     = 5'(a);
    Fetch_en2 = 1'b1;
    step();
    Fetch_en2 = 1'b0;
    chk($sformatf("fetch20[%0d]", a), 32'(Instruction2), 32'(exp));
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 100 && Loading; g++) step_ld();
  endtask

  initial begin
    Reset = 1'b1;
    Addr = '0; Fetch_en = 1'b0; Load_start = 1'b0; Load_valid = 1'b0;
    Load_data = '0; Load_last = 1'b0;
    Addr2 = '0; Fetch_en2 = 1'b0; Load_start2 = 1'b0; Load_valid2 = 1'b0;
    Load_data2 = '0; Load_last2 = 1'b0;

    // Reset
    step(); step();
    Reset = 1'b0;
    chk("rst_instr", 32'(Instruction), 32'h0);
    chk("rst_ready", 32'(Load_ready), 32'h0);
    chk("rst_loading", 32'(Loading), 32'h0);
    chk("rst_error", 32'(Load_error), 32'h0);
    chk("rst_count", 32'(Load_count), 32'h0);
    chk("rst_instr20", 32'(Instruction2), 32'h0);
    for (int a = 0; a < 32; a++) fetch(a, 10'h000);

    // Short load with fill
    cyc = 0;
    Load_start = 1'b1; step_ld(); Load_start = 1'b0;
    chk("start_ready", 32'(Load_ready), 32'h1);
    chk("start_loading", 32'(Loading), 32'h1);
    put(10'h3C1, 1'b0); put(10'h2A5, 1'b0); put(10'h155, 1'b1);
    chk("short_ready_fall", 32'(Load_ready), 32'h0);
    chk("short_count", 32'(Load_count), 32'd3);
    wait_idle();
    chk("short_cycles", 32'(cyc), 32'd32);
    chk("short_error", 32'(Load_error), 32'h0);
    fetch(0, 10'h3C1); fetch(1, 10'h2A5); fetch(2, 10'h155);
    for (int a = 3; a < 32; a++) fetch(a, 10'h000);

    // Full-depth load on the DEPTH=20 instance, then out-of-range fetches
    cyc2 = 0;
    Load_start2 = 1'b1; step2(); Load_start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      Load_valid2 = 1'b1;
      Load_data2  = 10'(32'h100 + i);
      Load_last2  = (i == 19);
      step2();
    end
    Load_valid2 = 1'b0; Load_last2 = 1'b0;
    chk("d20_loading", 32'(Loading2), 32'h0);
    chk("d20_error", 32'(Load_error2), 32'h0);
    chk("d20_count", 32'(Load_count2), 32'd20);
    chk("d20_cycles", 32'(cyc2), 32'd20);
    fetch2(19, 10'h113);
    fetch2(25, 10'h000);
    fetch2(0, 10'h100);
    fetch2(20, 10'h000);

    // Backpressure, with a stray Load_start mid-session and a fetch during fill
    fetch(1, 10'h2A5);
    cyc = 0;
    Load_start = 1'b1; step_ld(); Load_start = 1'b0;
    put(10'h0AA, 1'b0);
    Load_data = 10'h3FF;
    for (int g = 0; g < 4; g++) begin
      Load_start = (g == 2);
      step_ld();
      chk($sformatf("bp_ready[%0d]", g), 32'(Load_ready), 32'h1);
      chk($sformatf("bp_count[%0d]", g), 32'(Load_count), 32'd1);
    end
    Load_start = 1'b0;
    put(10'h155, 1'b0); put(10'h2F0, 1'b1);
    Addr = 5'd0; Fetch_en = 1'b1; step_ld(); Fetch_en = 1'b0;
    chk("fetch_while_loading", 32'(Instruction), 32'h0);
    wait_idle();
    chk("bp_cycles", 32'(cyc), 32'd36);
    chk("bp_count", 32'(Load_count), 32'd3);
    fetch(0, 10'h0AA); fetch(1, 10'h155); fetch(2, 10'h2F0); fetch(3, 10'h000); fetch(4, 10'h000);

    // Truncation: 32 words, Load_last never set
    cyc = 0;
    Load_start = 1'b1; step_ld(); Load_start = 1'b0;
    for (int i = 0; i < 32; i++) put(10'(i * 3 + 1), 1'b0);
    chk("trunc_loading", 32'(Loading), 32'h0);
    chk("trunc_error", 32'(Load_error), 32'h1);
    chk("trunc_count", 32'(Load_count), 32'd32);
    chk("trunc_ready", 32'(Load_ready), 32'h0);
    chk("trunc_cycles", 32'(cyc), 32'd32);
    Load_valid = 1'b1; Load_data = 10'h3FF; step(); Load_valid = 1'b0;
    chk("extra_count", 32'(Load_count), 32'd32);
    chk("extra_loading", 32'(Loading), 32'h0);
    fetch(0, 10'd1);
    fetch(31, 10'd94);
    Fetch_en = 1'b0; Addr = 5'd5; step(); Addr = 5'd0; step();
    chk("fetch_hold", 32'(Instruction), 32'd94);

    // Reset after 5 of 10 words
    Load_start = 1'b1; step(); Load_start = 1'b0;
    for (int i = 0; i < 5; i++) put(10'(32'h200 + i), 1'b0);
    chk("mid_count", 32'(Load_count), 32'd5);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("mid_loading", 32'(Loading), 32'h0);
    chk("mid_ready", 32'(Load_ready), 32'h0);
    chk("mid_count_rst", 32'(Load_count), 32'h0);
    chk("mid_error_rst", 32'(Load_error), 32'h0);
    chk("mid_instr_rst", 32'(Instruction), 32'h0);
    for (int a = 0; a < 5; a++) fetch(a, 10'(32'h200 + a));
    fetch(5, 10'd16);
    fetch(9, 10'd28);
    fetch(31, 10'd94);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_store.md
# program_store

Parametrised, field-loadable program memory for picoMips, replacing the fixed ROM. It holds `DEPTH` instructions of `INSTR_W` bits and serves the fetch stage with a one-cycle registered read. A valid/ready load port, active only when `Load_start` is pulsed, rewrites the program in place, filling unused tail locations with NOP. The core is stalled on NOPs while a load session runs.

## Interface
Parameters:
- `ADDR_W`, default 5: fetch and write address width.
- `INSTR_W`, default 10: instruction width (opcode plus immediate).
- `DEPTH`, default 2**ADDR_W: implemented locations. Must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W.
- `NOP_WORD`, default '0: fill value, reset value and fetch value for out-of-range addresses.

Ports:
- `Clock` in 1: single clock; all logic is on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Addr` in ADDR_W: fetch address.
- `Fetch_en` in 1: when 0, `Instruction` holds its value (core stall).
- `Instruction` out INSTR_W: registered fetch data.
- `Load_start` in 1: pulse that opens a load session.
- `Load_valid` in 1: load word present.
- `Load_data` in INSTR_W: load word.
- `Load_last` in 1: qualifies the final word of the session.
- `Load_ready` out 1: load port accepting.
- `Loading` out 1: session or fill in progress.
- `Load_count` out ADDR_W+1: words accepted in the current or last session.
- `Load_error` out 1: sticky truncation flag.

## Operation
- FSM states:
  - `IDLE`: `Load_start` moves the FSM to `LOAD` and resets the write pointer `wp`, `Load_count` and `Load_error` to 0.
  - `LOAD`: `Load_ready`=1. A word is accepted on each cycle with `Load_valid && Load_ready`. The word is written to `mem[wp]`, then `wp` and `Load_count` each increment by 1.
    - Accepted with `Load_last` and `wp` < DEPTH-1: go to `FILL`.
    - Accepted with `wp` = DEPTH-1: go to `IDLE`. If `Load_last` was 0 on that word, set `Load_error`=1.
  - `FILL`: write `NOP_WORD` to `mem[wp]` every cycle and increment `wp`. The cycle that writes DEPTH-1 returns to `IDLE`. `Load_count` does not change.
- `Load_start` is ignored outside `IDLE`.
- `Load_valid` is ignored while `Load_ready`=0, including the `Load_start` cycle itself.
- `Loading` = (state ≠ `IDLE`), taken from the registered state.
- Fetch:
  - `Fetch_en`=1: on the next edge `Instruction` ← `mem[Addr]`.
  - `Addr` ≥ DEPTH, or `Loading`=1: `Instruction` ← `NOP_WORD`.
- Reset:
  - State goes to `IDLE`.
  - `Instruction`=`NOP_WORD`; `Load_ready`, `Loading`, `Load_count`, `wp` and `Load_error` all go to 0.
  - Memory contents are not cleared by `Reset`.
- Initial memory contents at configuration: all `NOP_WORD`.
- Reset mid-session aborts the session at once. Locations already written keep their new values; unwritten locations keep their old values.
- `Load_error` persists until the next accepted `Load_start` or `Reset`.

## Timing
- Fetch latency is 1 cycle: `Addr` presented at edge N appears on `Instruction` after edge N+1.
- Load handshake:
  - Writes occur at the accepting edge, with zero added latency.
  - `Load_ready` rises on the first cycle after the `Load_start` edge.
  - `Load_ready` falls on the cycle after the last word is accepted.
- A session of K words (1 ≤ K ≤ DEPTH) holds `Loading` high for (K + stall cycles + DEPTH−K) cycles, where the fill phase takes DEPTH−K cycles (0 when K = DEPTH).
- The first fetch edge with `Loading`=0 returns new contents. There is no read-during-write hazard, because fetch is forced to NOP while loading.
- `Load_count` is valid one cycle after each accept and holds its value in `IDLE`.

## Structure
Package `picomips_pkg` holds:
- opcode constants (`OP_HEI`, `OP_LS`, `OP_MULI`, `OP_AR`, `OP_ADDR`, `OP_LR`, `OP_ADDI`);
- the `INSTR_W` default and `NOP_WORD`;
- the typedef `load_state_t` {`IDLE`, `LOAD`, `FILL`}.

Sub-module `program_store_ram` is a plain synchronous-write, synchronous-read array. It has one write port (`we`, `waddr`, `wdata`) and one read port (`raddr`, `rdata`). `program_store` contains the FSM, pointer, counters and output muxing.

## Test plan
Defaults apply unless stated.
- **Reset**: assert `Reset` for 2 cycles. Expect `Instruction`=0 and `Load_ready`=`Loading`=`Load_error`=0, with `Load_count`=0. Fetch of every address returns 0.
- **Short load with fill**: pulse `Load_start`, then send 3 words 0x3C1, 0x2A5, 0x155 (last on the third), valid every cycle. Expect `Loading` high for 32 cycles, `Load_count`=3, then fetch addresses 0–2 → those words and addresses 3–31 → 0.
- **Backpressure**: drop `Load_valid` for 4 cycles mid-session. Expect no writes and `wp` held, with `Load_ready` staying at 1 throughout. The final contents match the gap-free run.
- **Truncation**: send 32 words with `Load_last` never asserted. Expect the session to end after word 32, `Load_error`=1 and `Load_count`=32. A 33rd `Load_valid` is ignored (`Load_ready`=0).
- **Reset mid-load**: assert `Reset` after 5 of 10 words. Expect state `IDLE`, `Load_count`=0, addresses 0–4 holding the new words and addresses 5–31 holding the previous program.
- **Fetch edge cases**: set DEPTH=20 and fetch `Addr`=25 → NOP. Hold `Fetch_en`=0 while `Addr` changes → `Instruction` unchanged. Issue a fetch while `Loading`=1 → NOP.
